pipeline_controller: RTL

- Sequences the 4-stage RISC pipeline: IF, DOF (decode/operand fetch), EX, WB.
- Owns the PC and the IF/DOF instruction register, which feeds the instruction decoder.
- Tracks per-stage valid bits and destination registers, and detects RAW hazards against the decoder's AA/BA/MA/MB outputs.
- Resolves branches in EX from BS/PS/Z, generating stall, bubble and flush controls for the datapath.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipeline_controller_if.sv | 41 ++++
 rtl/hazard_detect.sv | 35 +++
 rtl/pipeline_controller.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 4-stage pipeline controller: branch-select
// encodings, the NOP opcode, the default register address width and the
// EX-stage branch resolution helper.
package pipe_pkg;

    localparam int RA_W = 4;

    localparam logic [6:0] NOP_OPCODE = 7'b0000000;

    typedef enum logic [1:0] {
        BS_INC  = 2'b00,
        BS_COND = 2'b01,
        BS_JMP  = 2'b10,
        BS_BRA  = 2'b11
    } bs_e;

    // Decide whether the instruction held in EX redirects the PC.
    // BS_COND with PS=0 is branch-on-zero, PS=1 is branch-on-nonzero.
    function automatic logic branch_taken(
        input logic       valid,
        input logic [1:0] bs,
        input logic       ps,
        input logic       z
    );
        logic take_s;
        case (bs)
            BS_INC:  take_s = 1'b0;
            BS_COND: take_s = (z != ps);
            BS_JMP:  take_s = 1'b1;
            BS_BRA:  take_s = 1'b1;
            default: take_s = 1'b0;
        endcase
        return valid & take_s;
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of the instruction-memory, decoder and datapath control signals
// between the pipeline controller (master) and its environment (slave).
interface pipeline_controller_if #(
    parameter int PC_W = 32,
    parameter int RA_W = 4
);
    // instruction memory
    logic [31:0]     IMEM_DATA;
    logic            IMEM_READY;
    logic [PC_W-1:0] IMEM_ADDR;
    // decoder side
    logic [31:0]     IR;
    logic            DOF_VALID;
    logic            RW;
    logic [RA_W-1:0] DA;
    logic [RA_W-1:0] AA;
    logic [RA_W-1:0] BA;
    logic            MA;
    logic            MB;
    logic [1:0]      BS;
    logic            PS;
    // datapath side
    logic            Z;
    logic [PC_W-1:0] BR_TARGET;
    logic            EX_VALID;
    logic            WB_VALID;
    logic [RA_W-1:0] WB_DA;
    logic            STALL;
    logic            FLUSH;

    modport master (
        input  IMEM_DATA, IMEM_READY, RW, DA, AA, BA, MA, MB, BS, PS, Z, BR_TARGET,
        output IMEM_ADDR, IR, DOF_VALID, EX_VALID, WB_VALID, WB_DA, STALL, FLUSH
    );

    modport slave (
        output IMEM_DATA, IMEM_READY, RW, DA, AA, BA, MA, MB, BS, PS, Z, BR_TARGET,
        input  IMEM_ADDR, IR, DOF_VALID, EX_VALID, WB_VALID, WB_DA, STALL, FLUSH
    );

endinterface

// File: rtl/hazard_detect.sv
// RAW hazard detection between the DOF-stage source operands and the
// destinations of the instructions currently in EX and WB. No forwarding
// exists, and R0 is treated like any other register.
module hazard_detect #(
    parameter int RA_W = 4
) (
    input  logic            dof_valid,
    input  logic            ma,
    input  logic            mb,
    input  logic [RA_W-1:0] aa,
    input  logic [RA_W-1:0] ba,
    input  logic            ex_valid,
    input  logic            ex_rw,
    input  logic [RA_W-1:0] ex_da,
    input  logic            wb_valid,
    input  logic            wb_rw,
    input  logic [RA_W-1:0] wb_da,
    output logic            hz_ex,
    output logic            hz_wb
);

    logic src_a_s;
    logic src_b_s;

    // Compare live register sources against live register-writing destinations.
    always_comb begin
        src_a_s = dof_valid & ~ma;
        src_b_s = dof_valid & ~mb;
        hz_ex   = ex_valid & ex_rw &
                  ((src_a_s & (aa == ex_da)) | (src_b_s & (ba == ex_da)));
        hz_wb   = wb_valid & wb_rw &
                  ((src_a_s & (aa == wb_da)) | (src_b_s & (ba == wb_da)));
    end

endmodule

// File: rtl/pipeline_controller.sv
// Sequencer for the IF / DOF / EX / WB pipeline. Owns the PC, the IF/DOF
// instruction register and the per-stage valid/destination tags; stalls on
// RAW hazards and flushes on branches resolved in EX (flush beats stall).
module pipeline_controller #(
    parameter int              PC_W     = 32,
    parameter int              RA_W     = pipe_pkg::RA_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RESET,
    pipeline_controller_if.master bus
);

    import pipe_pkg::*;

    // IF/DOF state
    logic [PC_W-1:0] pc_r;
    logic [31:0]     ir_r;
    logic            dof_valid_r;
    // EX state
    logic            ex_valid_r;
    logic            ex_rw_r;
    logic [RA_W-1:0] ex_da_r;
    logic [1:0]      ex_bs_r;
    logic            ex_ps_r;
    // WB state
    logic            wb_valid_r;
    logic            wb_rw_r;
    logic [RA_W-1:0] wb_da_r;
    // control
    logic            hz_ex_s;
    logic            hz_wb_s;
    logic            flush_s;
    logic            stall_s;
    logic            fetch_s;

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .dof_valid (dof_valid_r),
        .ma        (bus.MA),
        .mb        (bus.MB),
        .aa        (bus.AA),
        .ba        (bus.BA),
        .ex_valid  (ex_valid_r),
        .ex_rw     (ex_rw_r),
        .ex_da     (ex_da_r),
        .wb_valid  (wb_valid_r),
        .wb_rw     (wb_rw_r),
        .wb_da     (wb_da_r),
        .hz_ex     (hz_ex_s),
        .hz_wb     (hz_wb_s)
    );

    // Resolve branch in EX; a taken branch kills the DOF instruction, so its stall is dropped.
    always_comb begin
        flush_s = branch_taken(ex_valid_r, ex_bs_r, ex_ps_r, bus.Z);
        stall_s = (hz_ex_s | hz_wb_s) & ~flush_s;
        fetch_s = ~flush_s & ~stall_s & bus.IMEM_READY;
    end

    // PC, instruction register and DOF valid: redirect, hold, or fetch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_r        <= RESET_PC;
            ir_r        <= {NOP_OPCODE, 25'b0};
            dof_valid_r <= 1'b0;
        end else if (flush_s) begin
            pc_r        <= bus.BR_TARGET;
            ir_r        <= ir_r;
            dof_valid_r <= 1'b0;
        end else if (stall_s) begin
            pc_r        <= pc_r;
            ir_r        <= ir_r;
            dof_valid_r <= dof_valid_r;
        end else if (fetch_s) begin
            pc_r        <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            ir_r        <= bus.IMEM_DATA;
            dof_valid_r <= 1'b1;
        end else begin
            pc_r        <= pc_r;
            ir_r        <= ir_r;
            dof_valid_r <= 1'b0;
        end
    end

    // EX stage: take the decoded DOF tags; insert a bubble on stall or flush.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex_valid_r <= 1'b0;
            ex_rw_r    <= 1'b0;
            ex_da_r    <= {RA_W{1'b0}};
            ex_bs_r    <= 2'b00;
            ex_ps_r    <= 1'b0;
        end else begin
            ex_rw_r    <= bus.RW;
            ex_da_r    <= bus.DA;
            ex_bs_r    <= bus.BS;
            ex_ps_r    <= bus.PS;
            if (flush_s || stall_s) begin
                ex_valid_r <= 1'b0;
            end else begin
                ex_valid_r <= dof_valid_r;
            end
        end
    end

    // WB stage: always advances from EX, including the branch instruction itself.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wb_valid_r <= 1'b0;
            wb_rw_r    <= 1'b0;
            wb_da_r    <= {RA_W{1'b0}};
        end else begin
            wb_valid_r <= ex_valid_r;
            wb_rw_r    <= ex_rw_r;
            wb_da_r    <= ex_da_r;
        end
    end

    // Drive the bus from the stage registers and the control decisions.
    always_comb begin
        bus.IMEM_ADDR = pc_r;
        bus.IR        = ir_r;
        bus.DOF_VALID = dof_valid_r;
        bus.EX_VALID  = ex_valid_r;
        bus.WB_VALID  = wb_valid_r;
        bus.WB_DA     = wb_da_r;
        bus.STALL     = stall_s;
        bus.FLUSH     = flush_s;
    end

endmodule
